// File: rtl/pipe_credit_pkg.sv
// Shared helpers for the credit-gated pipeline output buffer: counter/pointer
// widths and the add/subtract event encoding used by its counters.
package pipe_credit_pkg;

  localparam logic [1:0] EV_NONE = 2'b00;
  localparam logic [1:0] EV_SUB  = 2'b01;
  localparam logic [1:0] EV_ADD  = 2'b10;
  localparam logic [1:0] EV_BOTH = 2'b11;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A single-entry buffer still needs a one-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_credit_fifo_if.sv
// Handshake and data bundle of pipe_credit_fifo: launch side, pipeline tail
// side and consumer side.
interface pipe_credit_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  import pipe_credit_pkg::*;

  localparam int CW = cnt_width(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic             issue;
  logic             pipe_valid;
  logic [WIDTH-1:0] pipe_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             err;

  modport slave (
    input  in_valid, pipe_valid, pipe_data, out_ready,
    output in_ready, issue, out_valid, out_data, count, err
  );

  modport master (
    output in_valid, pipe_valid, pipe_data, out_ready,
    input  in_ready, issue, out_valid, out_data, count, err
  );

endinterface

// File: rtl/pipe_credit_ram.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// asynchronous read port, so the head entry falls through to the output.
module pipe_credit_ram
  import pipe_credit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_credit_fifo.sv
// Credit-gated FWFT buffer around a fixed-latency valid-only pipeline.
// Optional overflow/credit checking is built when PIPE_CREDIT_FIFO_ERR_EN is defined.
module pipe_credit_fifo
  import pipe_credit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DELAY = 4,
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  pipe_credit_fifo_if.slave   io
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  if (DEPTH < 1 || DELAY < 0) begin : g_param_check
    $error("pipe_credit_fifo: DEPTH must be >= 1 and DELAY >= 0");
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : (p + PW'(1));
  endfunction

  logic [CW-1:0] cred_q, cred_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          issue_s, pop_s, wr_s;

`ifdef PIPE_CREDIT_FIFO_ERR_EN
  logic          err_q, err_d;
  logic          ovf_s, cred_ovf_s;
`endif

  assign issue_s = io.in_valid & in_ready_q;
  assign pop_s   = out_valid_q & io.out_ready;

`ifdef PIPE_CREDIT_FIFO_ERR_EN
  // A write into a full buffer with no pop leaving is discarded and flagged.
  assign ovf_s      = io.pipe_valid & (count_q == DEPTH_C) & ~pop_s;
  assign cred_ovf_s = pop_s & ~issue_s & (cred_q == DEPTH_C);
  assign wr_s       = io.pipe_valid & ~ovf_s;
`else
  assign wr_s       = io.pipe_valid;
`endif

  always_comb begin
    cred_d = cred_q;
    case ({pop_s, issue_s})
      EV_ADD:  cred_d = (cred_q == DEPTH_C) ? cred_q : (cred_q + CNT_ONE);
      EV_SUB:  cred_d = cred_q - CNT_ONE;
      EV_BOTH: cred_d = cred_q;
      EV_NONE: cred_d = cred_q;
      default: cred_d = cred_q;
    endcase

    count_d = count_q;
    case ({wr_s, pop_s})
      EV_ADD:  count_d = count_q + CNT_ONE;
      EV_SUB:  count_d = count_q - CNT_ONE;
      EV_BOTH: count_d = count_q;
      EV_NONE: count_d = count_q;
      default: count_d = count_q;
    endcase

    if (wr_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    in_ready_d  = (cred_d != {CW{1'b0}});
    out_valid_d = (count_d != {CW{1'b0}});

`ifdef PIPE_CREDIT_FIFO_ERR_EN
    err_d = err_q | ovf_s | cred_ovf_s;
`endif
  end

  // The credit pool starts full while in_ready starts low, so launches begin one cycle after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cred_q      <= DEPTH_C;
      count_q     <= {CW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef PIPE_CREDIT_FIFO_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      cred_q      <= cred_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef PIPE_CREDIT_FIFO_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  pipe_credit_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_s),
    .waddr (wr_ptr_q),
    .wdata (io.pipe_data),
    .raddr (rd_ptr_q),
    .rdata (io.out_data)
  );

  assign io.in_ready  = in_ready_q;
  assign io.issue     = issue_s;
  assign io.out_valid = out_valid_q;
  assign io.count     = count_q;
`ifdef PIPE_CREDIT_FIFO_ERR_EN
  assign io.err       = err_q;
`else
  assign io.err       = 1'b0;
`endif

endmodule
